seq_mult: RTL and testbench
===========================

SEQ_MULT -- requirements
Module: seq_mult

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits, legal range 2..32.
REQ-002 SHALL have parameter APPROX_COLS, default 0, number of low product columns truncated (0..WIDTH); used only with SEQ_MULT_APPROX_EN.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  operands a/b valid.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port a  input  WIDTH  unsigned multiplicand.
REQ-008 SHALL have port b  input  WIDTH  unsigned multiplier.
REQ-009 SHALL have port out_valid  output  1  product valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts product.
REQ-011 SHALL have port product  output  2*WIDTH  unsigned result.
REQ-012 SHALL have port busy  output  1  high in CALC or DONE.

Function
REQ-013 SHALL implement FSM IDLE, CALC, DONE; radix-2 shift-add, one multiplier bit per cycle.
REQ-014 SHALL drive in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-015 SHALL, on in_valid&&in_ready at edge k, register a, b, clear 2*WIDTH accumulator and bit counter, enter CALC.
REQ-016 SHALL in CALC add (a<<i) gated by b[i] into accumulator for i=0..WIDTH-1, one i per cycle, counter width clog2(WIDTH+1).
REQ-017 SHALL enter DONE after edge k+WIDTH, so out_valid first high in the cycle following edge k+WIDTH.
REQ-018 SHALL hold product and out_valid stable while out_valid&&!out_ready (no data change under backpressure).
REQ-019 SHALL, on out_valid&&out_ready, return to IDLE; in_ready rises the next cycle (no same-cycle bypass).
REQ-020 SHALL ignore in_valid outside IDLE and ignore out_ready outside DONE.
REQ-021 SHALL produce exact a*b in 2*WIDTH bits with no overflow (approximation off).
REQ-022 SHALL drive product from accumulator register; product value outside DONE is don't-care but SHALL be 0 after reset.

Reset
REQ-023 SHALL on rst_n low asynchronously force state IDLE, accumulator, counter, registered operands to 0; in_ready=1 after release, out_valid=0, busy=0, product=0.
REQ-024 SHALL abort any CALC/DONE transaction on reset with no product delivered.

Configuration
REQ-025 SHALL, with SEQ_MULT_APPROX_EN defined, zero every partial-product bit in columns < APPROX_COLS before accumulation (low APPROX_COLS product bits always 0).
REQ-026 SHALL, without SEQ_MULT_APPROX_EN, ignore APPROX_COLS and compute exactly; latency identical in both builds.

Structure
REQ-027 SHALL place state enum and default WIDTH constant in shared package seq_mult_pkg.
REQ-028 SHALL implement one sub-module seq_mult_pp_row: gates shifted a by b[i] and applies approximation column mask.

Verification
REQ-029 SHALL cover: WIDTH=16, a=0xFFFF, b=0xFFFF accepted at edge k -> out_valid after edge k+16, product=0xFFFE0001.
REQ-030 SHALL cover: a=0x0000, b=0x1234 -> product=0; a=0x0001, b=0xABCD -> product=0x0000ABCD.
REQ-031 SHALL cover: out_ready held 0 for 10 cycles in DONE -> product/out_valid stable, in_ready=0, in_valid pulses ignored; then out_ready=1 -> IDLE next cycle.
REQ-032 SHALL cover: rst_n asserted at CALC cycle 5 -> immediate out_valid=0, busy=0, product=0; new operands 3*5 after release -> product=15.
REQ-033 SHALL cover: SEQ_MULT_APPROX_EN, APPROX_COLS=4, a=0x000F, b=0x000F -> product=0x00B0 (exact build 0x00E1).
REQ-034 SHALL cover: back-to-back transactions with in_valid held high -> each accepted one cycle after prior out handshake, 18-cycle period at WIDTH=16.

Source files
------------

// File: rtl/seq_mult_pkg.sv
// Shared constants and FSM encoding for the sequential shift-add multiplier.
package seq_mult_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  // Plain-vector aliases so state registers stay ordinary logic vectors.
  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_CALC = ST_CALC;
  localparam logic [1:0] S_DONE = ST_DONE;

endpackage

// File: rtl/seq_mult_pp_row.sv
// One partial-product row: a shifted into column position 'shift',
// gated by the current multiplier bit.
// Optional build macro SEQ_MULT_APPROX_EN: clears every partial-product bit
// in columns below APPROX_COLS before it reaches the accumulator.
module seq_mult_pp_row #(
  parameter int WIDTH       = 16,
  parameter int APPROX_COLS = 0,
  parameter int CW          = 5
) (
  input  logic [WIDTH-1:0]   a,
  input  logic               b_bit,
  input  logic [CW-1:0]      shift,
  output logic [2*WIDTH-1:0] pp
);

`ifdef SEQ_MULT_APPROX_EN
  localparam logic [2*WIDTH-1:0] COL_MASK =
    ~(((2*WIDTH)'(1) << APPROX_COLS) - (2*WIDTH)'(1));
`else
  // Exact build: mask keeps every column whatever APPROX_COLS says.
  localparam logic [2*WIDTH-1:0] COL_MASK = (APPROX_COLS >= 0) ? '1 : '1;
`endif

  logic [2*WIDTH-1:0] shifted;

  // Gate the shifted multiplicand by the multiplier bit, then mask columns.
  always_comb begin
    shifted = {{WIDTH{1'b0}}, a} << shift;
    pp      = b_bit ? (shifted & COL_MASK) : '0;
  end

endmodule

// File: rtl/seq_mult.sv
// Radix-2 sequential multiplier: IDLE -> CALC (WIDTH cycles) -> DONE.
// Optional build macro SEQ_MULT_APPROX_EN truncates low product columns.
module seq_mult
  import seq_mult_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int APPROX_COLS = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [1:0]         state;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;   // shifted right each CALC cycle; b_q[0] is bit i
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] pp;
  logic [CW-1:0]      cnt;

  seq_mult_pp_row #(
    .WIDTH(WIDTH), .APPROX_COLS(APPROX_COLS), .CW(CW)
  ) u_pp_row (
    .a(a_q), .b_bit(b_q[0]), .shift(cnt), .pp(pp)
  );

  // FSM plus datapath: capture operands, accumulate one row per cycle, hold result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      a_q   <= '0;
      b_q   <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            acc   <= '0;
            cnt   <= '0;
            state <= S_CALC;
          end
        end
        S_CALC: begin
          acc <= acc + pp;
          b_q <= b_q >> 1;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Handshake flags decode straight from state; product is the accumulator.
  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
    busy      = (state != S_IDLE);
    product   = acc;
  end

endmodule

// File: tb/tb_seq_mult.sv
// Self-checking bench for seq_mult (WIDTH=16, APPROX_COLS=4).
module tb_seq_mult;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] product;
  logic        busy;

  int nvec = 0;
  int nerr = 0;

  seq_mult #(.WIDTH(16), .APPROX_COLS(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: plain multiplication, or column-truncated sum of shifted rows.
  function automatic logic [31:0] ref_prod(input logic [15:0] x, input logic [15:0] y);
`ifdef SEQ_MULT_APPROX_EN
    logic [31:0] s = '0;
    for (int i = 0; i < 16; i++)
      if (y[i]) s = s + ((32'(x) << i) & ~32'hF);
    return s;
`else
    return 32'(x) * 32'(y);
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Full transaction: wait ready, offer operands, measure latency, take result.
  task automatic run(input string name, input logic [15:0] x, input logic [15:0] y,
                     input logic [31:0] exp);
    int lat;
    int w;
    w = 0;
    while (!in_ready && w < 100) begin @(posedge clk); #1; w++; end
    check({name, "_ready_to"}, 32'(w < 100), 32'd1);
    a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;              // edge k: accepted
    in_valid = 1'b0;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!out_valid && lat < 40);
    check({name, "_lat"}, 32'(lat), 32'd16);
    check({name, "_prod"}, product, exp);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, "_idle"}, {30'd0, in_ready, out_valid}, 32'b10);
  endtask

  typedef struct {
    string       name;
    logic [15:0] x;
    logic [15:0] y;
    logic [31:0] exact;
  } vec_t;

  vec_t tbl[5];

  initial begin
    logic [31:0] held;
    logic [31:0] exp;
    logic [15:0] rx, ry;
    logic [31:0] q[$];
    int cyc, last, nacc, prev_rdy, nout;

    tbl[0] = '{"ffff_sq", 16'hFFFF, 16'hFFFF, 32'hFFFE0001};
    tbl[1] = '{"zero_a",  16'h0000, 16'h1234, 32'h00000000};
    tbl[2] = '{"one_a",   16'h0001, 16'hABCD, 32'h0000ABCD};
    tbl[3] = '{"three5",  16'h0003, 16'h0005, 32'h0000000F};
    tbl[4] = '{"f_sq",    16'h000F, 16'h000F, 32'h000000E1};

    // Reset state
    #12;
    check("rst_flags", {29'd0, in_ready, out_valid, busy}, 32'b100);
    check("rst_prod", product, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_flags", {29'd0, in_ready, out_valid, busy}, 32'b100);

    // Table vectors
    for (int i = 0; i < 5; i++) begin
`ifdef SEQ_MULT_APPROX_EN
      exp = ref_prod(tbl[i].x, tbl[i].y);
`else
      exp = tbl[i].exact;
`endif
      run(tbl[i].name, tbl[i].x, tbl[i].y, exp);
    end
`ifdef SEQ_MULT_APPROX_EN
    run("approx_f_sq", 16'h000F, 16'h000F, 32'h000000B0);
`endif

    // Random vectors against the model
    for (int i = 0; i < 8; i++) begin
      rx = 16'($urandom); ry = 16'($urandom);
      run("rand", rx, ry, ref_prod(rx, ry));
    end

    // Backpressure: hold DONE for 10 cycles with stray in_valid pulses
    a = 16'h1234; b = 16'h0010; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 40 && !out_valid; i++) begin @(posedge clk); #1; end
    check("bp_valid", 32'(out_valid), 32'd1);
    held = product;
    check("bp_prod", held, ref_prod(16'h1234, 16'h0010));
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0]; a = 16'($urandom); b = 16'($urandom);
      @(posedge clk); #1;
      check("bp_hold", {product}, held);
      check("bp_flags", {30'd0, out_valid, in_ready}, 32'b10);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release", {30'd0, in_ready, out_valid}, 32'b10);

    // Reset during CALC cycle 5
    a = 16'h0007; b = 16'h0009; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_flags", {30'd0, out_valid, busy}, 32'b00);
    check("mid_rst_prod", product, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run("after_rst", 16'd3, 16'd5, ref_prod(16'd3, 16'd5));

    // Back-to-back with in_valid and out_ready held high
    rx = 16'($urandom); ry = 16'($urandom);
    a = rx; b = ry; in_valid = 1'b1; out_ready = 1'b1;
    prev_rdy = int'(in_ready); last = 0; nacc = 0; nout = 0; cyc = 0;
    while (nout < 4 && cyc < 400) begin
      @(posedge clk); #1; cyc++;
      if (prev_rdy != 0) begin
        q.push_back(ref_prod(rx, ry));
        if (nacc > 0) check("b2b_period", 32'(cyc - last), 32'd18);
        last = cyc; nacc++;
        rx = 16'($urandom); ry = 16'($urandom);
        a = rx; b = ry;
      end
      if (out_valid) begin
        if (q.size() == 0) check("b2b_spurious", 32'd1, 32'd0);
        else check("b2b_prod", product, q.pop_front());
        nout++;
      end
      prev_rdy = int'(in_ready);
    end
    check("b2b_done", 32'(nout), 32'd4);
    in_valid = 1'b0; out_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
